// File: rtl/pc_unit.sv
// pc_unit: program counter with relative branch page-cross fixup and return-address stack.
module pc_unit #(
    parameter int ADDR_W = 16,
    parameter int OFF_W = 8,
    parameter int STACK_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              increment_i,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_addr_i,
    input  logic              jsr_i,
    input  logic [ADDR_W-1:0] jsr_addr_i,
    input  logic              rts_i,
    input  logic              branch_i,
    input  logic [OFF_W-1:0]  branch_off_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              carry_o,
    output logic              busy_o,
    output logic              page_cross_o,
    output logic [SP_W-1:0]   sp_o,
    output logic              stack_full_o,
    output logic              stack_empty_o,
    output logic              ovf_err_o,
    output logic              unf_err_o
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FIXUP = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [ADDR_W-9:0]  hi_q, hi_d;
    logic               pcr_q, pcr_d, ovf_q, ovf_d, unf_q, unf_d, push;
    // Power-of-two depth keeps the sp-indexed select width-exact; extra entries are never written.
    logic [ADDR_W-1:0]  stack_q [2**SP_W];
    logic [ADDR_W-1:0]  base, target;
    logic signed [ADDR_W-1:0] off_ext;
    logic [SP_W-1:0]    top_idx;

    assign base = pc_q + ADDR_W'(increment_i);
    assign off_ext = ADDR_W'($signed(branch_off_i));
    assign target = base + off_ext;
    assign top_idx = sp_q - SP_W'(1);
    assign stack_full_o = sp_q == SP_W'(STACK_DEPTH);
    assign stack_empty_o = sp_q == '0;
    assign carry_o = state_q == IDLE && increment_i && !(load_i || jsr_i || rts_i || branch_i) && &pc_q;
    assign pc_o = pc_q;
    assign busy_o = state_q == FIXUP;
    assign page_cross_o = pcr_q;
    assign sp_o = sp_q;
    assign ovf_err_o = ovf_q;
    assign unf_err_o = unf_q;

    always_comb begin
        pc_d = base;
        sp_d = sp_q;
        state_d = IDLE;
        hi_d = hi_q;
        pcr_d = 1'b0;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push = 1'b0;
        if (state_q == FIXUP) begin
            pc_d = {hi_q, pc_q[7:0]};
        end else if (load_i) begin
            pc_d = load_addr_i;
        end else if (jsr_i) begin
            if (!stack_full_o) begin
                push = 1'b1;
                pc_d = jsr_addr_i;
                sp_d = sp_q + SP_W'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (rts_i) begin
            if (!stack_empty_o) begin
                pc_d = stack_q[top_idx];
                sp_d = top_idx;
            end else begin
                unf_d = 1'b1;
            end
        end else if (branch_i) begin
            if (target[ADDR_W-1:8] == base[ADDR_W-1:8]) begin
                pc_d = target;
            end else begin
                pc_d = {base[ADDR_W-1:8], target[7:0]};
                hi_d = target[ADDR_W-1:8];
                pcr_d = 1'b1;
                state_d = FIXUP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pc_q <= RESET_ADDR;
            sp_q <= '0;
            hi_q <= '0;
            pcr_q <= 1'b0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q <= pc_d;
            sp_q <= sp_d;
            hi_q <= hi_d;
            pcr_q <= pcr_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) stack_q[sp_q] <= base;
    end
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed scoreboard bench for pc_unit with the default parameters.
module tb_pc_unit;
    logic        clk = 0, reset, increment, load, jsr, rts, branch;
    logic [15:0] load_addr, jsr_addr, pc;
    logic [7:0]  branch_off;
    logic        carry, busy, page_cross, stack_full, stack_empty, ovf_err, unf_err;
    logic [2:0]  sp;
    int          checks = 0, errors = 0;

    typedef struct {
        logic [15:0] pc;
        logic        busy, pcr;
        logic [2:0]  sp;
        logic        ovf, unf;
    } exp_t;
    exp_t exp_q[$];

    pc_unit dut (
        .clk_i(clk), .reset_i(reset), .increment_i(increment), .load_i(load),
        .load_addr_i(load_addr), .jsr_i(jsr), .jsr_addr_i(jsr_addr), .rts_i(rts),
        .branch_i(branch), .branch_off_i(branch_off), .pc_o(pc), .carry_o(carry),
        .busy_o(busy), .page_cross_o(page_cross), .sp_o(sp), .stack_full_o(stack_full),
        .stack_empty_o(stack_empty), .ovf_err_o(ovf_err), .unf_err_o(unf_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic drv(input logic r, inc, ld, input logic [15:0] la, input logic j,
                       input logic [15:0] ja, input logic rt, br, input logic [7:0] bo);
        reset = r; increment = inc; load = ld; load_addr = la; jsr = j; jsr_addr = ja;
        rts = rt; branch = br; branch_off = bo;
    endtask

    task automatic cyc(input string tag, input logic [15:0] epc, input logic eb, epcr,
                       input logic [2:0] esp, input logic eo, eu);
        exp_t e;
        exp_q.push_back('{epc, eb, epcr, esp, eo, eu});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, ".pc"}, 32'(pc), 32'(e.pc));
        chk({tag, ".busy"}, 32'(busy), 32'(e.busy));
        chk({tag, ".page_cross"}, 32'(page_cross), 32'(e.pcr));
        chk({tag, ".sp"}, 32'(sp), 32'(e.sp));
        chk({tag, ".ovf"}, 32'(ovf_err), 32'(e.ovf));
        chk({tag, ".unf"}, 32'(unf_err), 32'(e.unf));
    endtask

    initial begin
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        cyc("reset", 16'h0000, 0, 0, 0, 0, 0);
        chk("reset.empty", 32'(stack_empty), 1);
        chk("reset.full", 32'(stack_full), 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("inc1", 16'h0001, 0, 0, 0, 0, 0);
        cyc("inc2", 16'h0002, 0, 0, 0, 0, 0);
        cyc("inc3", 16'h0003, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 16'hFFFF, 0, 0, 0, 0, 0);
        cyc("load_ffff", 16'hFFFF, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1 chk("carry_hi", 32'(carry), 1);
        cyc("wrap", 16'h0000, 0, 0, 0, 0, 0);
        chk("carry_lo", 32'(carry), 0);
        cyc("inc_after_wrap", 16'h0001, 0, 0, 0, 0, 0);
        drv(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset_again", 16'h0000, 0, 0, 0, 0, 0);

        drv(0, 0, 1, 16'h1234, 0, 0, 0, 0, 0);
        cyc("load_1234", 16'h1234, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 8'h10);
        cyc("br_fwd", 16'h1245, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 16'h1234, 0, 0, 0, 0, 0);
        cyc("load_1234b", 16'h1234, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 8'h80);
        cyc("br_back_cross", 16'h12B5, 1, 1, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("br_back_fix", 16'h11B5, 0, 0, 0, 0, 0);

        drv(0, 0, 1, 16'h12F0, 0, 0, 0, 0, 0);
        cyc("load_12f0", 16'h12F0, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 8'h20);
        cyc("br_cross", 16'h1211, 1, 1, 0, 0, 0);
        drv(0, 1, 1, 16'hAAAA, 0, 0, 0, 0, 0);
        #1 chk("carry_in_fixup", 32'(carry), 0);
        cyc("fixup_ignores_load", 16'h1311, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("after_fixup", 16'h1311, 0, 0, 0, 0, 0);

        drv(0, 0, 1, 16'h0100, 0, 0, 0, 0, 0);
        cyc("load_0100", 16'h0100, 0, 0, 0, 0, 0);
        drv(0, 1, 0, 0, 1, 16'h2000, 0, 0, 0);
        cyc("jsr1", 16'h2000, 0, 0, 1, 0, 0);
        cyc("jsr2", 16'h2000, 0, 0, 2, 0, 0);
        cyc("jsr3", 16'h2000, 0, 0, 3, 0, 0);
        cyc("jsr4", 16'h2000, 0, 0, 4, 0, 0);
        chk("full", 32'(stack_full), 1);
        chk("not_empty", 32'(stack_empty), 0);
        cyc("jsr_ovf", 16'h2001, 0, 0, 4, 1, 0);
        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("rts1", 16'h2001, 0, 0, 3, 1, 0);
        chk("not_full", 32'(stack_full), 0);
        cyc("rts2", 16'h2001, 0, 0, 2, 1, 0);
        cyc("rts3", 16'h2001, 0, 0, 1, 1, 0);
        cyc("rts4", 16'h0101, 0, 0, 0, 1, 0);
        chk("empty", 32'(stack_empty), 1);
        cyc("rts_unf", 16'h0101, 0, 0, 0, 1, 1);

        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset3", 16'h0000, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 1, 16'h3000, 1, 0, 0);
        cyc("jsr_rts", 16'h3000, 0, 0, 1, 0, 0);
        drv(0, 0, 1, 16'h4000, 0, 0, 0, 1, 8'h80);
        cyc("load_br", 16'h4000, 0, 0, 1, 0, 0);

        drv(0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc("rts_pop", 16'h0000, 0, 0, 0, 0, 0);
        cyc("rts_unf2", 16'h0000, 0, 0, 0, 0, 1);
        drv(0, 0, 1, 16'h12F0, 0, 0, 0, 0, 0);
        cyc("load_12f0b", 16'h12F0, 0, 0, 0, 0, 1);
        drv(0, 1, 0, 0, 0, 0, 0, 1, 8'h20);
        cyc("br_cross2", 16'h1211, 1, 1, 0, 0, 1);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("reset_in_fixup", 16'h0000, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc("idle_after_abort", 16'h0000, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
